// File: rtl/phys_free_list_pkg.sv
// Shared rename definitions: physical register sizing, prd and free-list pointer types.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package phys_free_list_pkg;

    localparam int REG_SIZE       = 64;
    localparam int REG_SIZE_WIDTH = 6;

    // Physical register address.
    typedef logic [REG_SIZE_WIDTH-1:0] preg_t;

    // Free-list pointer: array index plus one wrap bit.
    typedef logic [REG_SIZE_WIDTH:0] fl_ptr_t;

    // P0 is hardwired and never enters or leaves the free list.
    localparam preg_t PREG_ZERO = '0;

    function automatic fl_ptr_t fl_ptr_inc(input fl_ptr_t ptr);
        return ptr + fl_ptr_t'(1);
    endfunction

endpackage

// File: rtl/phys_free_list.sv
// Rename free list of physical registers with speculative/architectural heads for flush recovery.
// Latency: alloc_preg is combinational from state; a released prd is allocatable the cycle after release.
// Backpressure: alloc_ready=0 when no free prd; alloc_req while not ready is ignored (rename stalls).
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   alloc_req             rename wants one prd this cycle
//   alloc_ready/preg      a free prd is offered / the prd offered
//   commit_alloc_valid    a retiring instruction had allocated a prd (advances arch head)
//   release_valid/preg    commit returns one prd (old mapping of retiring rd)
//   flush                 restore speculative head from architectural head
//   free_count, empty     entries between speculative head and tail
//
// Build option: define FREELIST_BYPASS_EN to forward a same-cycle release straight to
// alloc_preg while the list is empty.
module phys_free_list
    import phys_free_list_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alloc_req,
    output logic                      alloc_ready,
    output logic [REG_SIZE_WIDTH-1:0] alloc_preg,
    input  logic                      commit_alloc_valid,
    input  logic                      release_valid,
    input  logic [REG_SIZE_WIDTH-1:0] release_preg,
    input  logic                      flush,
    output logic [REG_SIZE_WIDTH:0]   free_count,
    output logic                      empty
);

    preg_t   entry [REG_SIZE];
    fl_ptr_t spec_head;
    fl_ptr_t arch_head;
    fl_ptr_t tail;

    fl_ptr_t arch_head_next;
    fl_ptr_t spec_head_next;
    logic    release_ok;
    logic    commit_ok;
    logic    alloc_fire;

    assign free_count = tail - spec_head;
    assign empty      = (free_count == '0);

    // The array can hold at most REG_SIZE-1 prds counted from the architectural head;
    // anything beyond that is an upstream double free and is discarded.
    assign release_ok = release_valid && (release_preg != PREG_ZERO)
                        && ((tail - arch_head) != fl_ptr_t'(REG_SIZE - 1));

    // The architectural head may only consume entries rename has already handed out.
    assign commit_ok      = commit_alloc_valid && (arch_head != spec_head);
    assign arch_head_next = commit_ok ? fl_ptr_inc(arch_head) : arch_head;

`ifdef FREELIST_BYPASS_EN
    logic bypass;

    // While empty, spec_head == tail, so the forwarded prd is the same entry that the
    // release writes this cycle; advancing both pointers keeps the array consistent.
    assign bypass      = empty && release_ok;
    assign alloc_ready = !empty || bypass;
    assign alloc_preg  = bypass ? release_preg : entry[spec_head[REG_SIZE_WIDTH-1:0]];
`else
    assign alloc_ready = !empty;
    assign alloc_preg  = entry[spec_head[REG_SIZE_WIDTH-1:0]];
`endif

    assign alloc_fire = alloc_req && alloc_ready && !flush;

    always_comb begin
        spec_head_next = spec_head;
        if (flush) begin
            spec_head_next = arch_head_next;
        end else if (alloc_fire) begin
            spec_head_next = fl_ptr_inc(spec_head);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // Entries hold prds 1..REG_SIZE-1; the last slot is unused and parked at P0.
            for (int i = 0; i < REG_SIZE; i++) begin
                entry[i] <= (i == REG_SIZE - 1) ? PREG_ZERO : preg_t'(i + 1);
            end
            spec_head <= '0;
            arch_head <= '0;
            tail      <= fl_ptr_t'(REG_SIZE - 1);
        end else begin
            if (release_ok) begin
                entry[tail[REG_SIZE_WIDTH-1:0]] <= release_preg;
                tail                            <= fl_ptr_inc(tail);
            end
            arch_head <= arch_head_next;
            spec_head <= spec_head_next;
        end
    end

endmodule

// File: tb/tb_phys_free_list.sv
// Directed self-checking bench for phys_free_list.
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns after the following posedge.
// Backpressure: exercises alloc_req while empty and releases while empty.
module tb_phys_free_list;

    logic       clk;
    logic       reset;
    logic       alloc_req;
    logic       alloc_ready;
    logic [5:0] alloc_preg;
    logic       commit_alloc_valid;
    logic       release_valid;
    logic [5:0] release_preg;
    logic       flush;
    logic [6:0] free_count;
    logic       empty;

    int checks = 0;
    int errors = 0;

    phys_free_list dut (
        .clk                (clk),
        .reset              (reset),
        .alloc_req          (alloc_req),
        .alloc_ready        (alloc_ready),
        .alloc_preg         (alloc_preg),
        .commit_alloc_valid (commit_alloc_valid),
        .release_valid      (release_valid),
        .release_preg       (release_preg),
        .flush              (flush),
        .free_count         (free_count),
        .empty              (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req          = 1'b0;
        commit_alloc_valid = 1'b0;
        release_valid      = 1'b0;
        release_preg       = '0;
        flush              = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (free_count !== 7'd63) begin errors++; $display("FAIL reset_free_count: got %0d expected 63", free_count); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL reset_empty: got %0b expected 0", empty); end
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %0b expected 1", alloc_ready); end
        checks++; if (alloc_preg !== 6'd1) begin errors++; $display("FAIL reset_alloc_preg: got %0d expected 1", alloc_preg); end
    endtask

    task automatic test_release_p0();
        do_reset();
        release_valid = 1'b1; release_preg = 6'd0;
        step();
        idle();
        checks++; if (free_count !== 7'd63) begin errors++; $display("FAIL p0_release_count: got %0d expected 63", free_count); end
        checks++; if (alloc_preg !== 6'd1) begin errors++; $display("FAIL p0_release_preg: got %0d expected 1", alloc_preg); end
        // List is full relative to the architectural head: a non-zero release is an overflow.
        release_valid = 1'b1; release_preg = 6'd9;
        step();
        idle();
        checks++; if (free_count !== 7'd63) begin errors++; $display("FAIL overflow_release_count: got %0d expected 63", free_count); end
    endtask

    task automatic test_drain();
        do_reset();
        for (int p = 1; p <= 63; p++) begin
            checks++; if (alloc_preg !== 6'(p)) begin errors++; $display("FAIL drain_preg: got %0d expected %0d", alloc_preg, p); end
            alloc_req = 1'b1;
            step();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0b expected 1", empty); end
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL drain_alloc_ready: got %0b expected 0", alloc_ready); end
        checks++; if (free_count !== 7'd0) begin errors++; $display("FAIL drain_free_count: got %0d expected 0", free_count); end
        step();   // 64th request while empty
        idle();
        checks++; if (free_count !== 7'd0) begin errors++; $display("FAIL alloc_when_empty_count: got %0d expected 0", free_count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL alloc_when_empty_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_alloc_release();
        do_reset();
        alloc_req = 1'b1;
        repeat (10) step();
        idle();
        commit_alloc_valid = 1'b1;
        step();
        idle();
        checks++; if (free_count !== 7'd53) begin errors++; $display("FAIL ar_setup_count: got %0d expected 53", free_count); end
        checks++; if (alloc_preg !== 6'd11) begin errors++; $display("FAIL ar_setup_preg: got %0d expected 11", alloc_preg); end
        alloc_req = 1'b1; release_valid = 1'b1; release_preg = 6'd5;
        step();
        idle();
        checks++; if (free_count !== 7'd53) begin errors++; $display("FAIL ar_same_cycle_count: got %0d expected 53", free_count); end
        checks++; if (alloc_preg !== 6'd12) begin errors++; $display("FAIL ar_same_cycle_preg: got %0d expected 12", alloc_preg); end
        for (int p = 12; p <= 63; p++) begin
            checks++; if (alloc_preg !== 6'(p)) begin errors++; $display("FAIL ar_drain_preg: got %0d expected %0d", alloc_preg, p); end
            alloc_req = 1'b1;
            step();
        end
        idle();
        checks++; if (alloc_preg !== 6'd5) begin errors++; $display("FAIL ar_reissue_preg: got %0d expected 5", alloc_preg); end
        checks++; if (free_count !== 7'd1) begin errors++; $display("FAIL ar_reissue_count: got %0d expected 1", free_count); end
        alloc_req = 1'b1;
        step();
        idle();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ar_final_empty: got %0b expected 1", empty); end
    endtask

    // Continues from the empty list left by test_alloc_release (arch_head=1, tail=spec_head=64).
    task automatic test_empty_release();
        commit_alloc_valid = 1'b1;
        step();
        idle();
        alloc_req = 1'b1; release_valid = 1'b1; release_preg = 6'd7;
        #1;
`ifdef FREELIST_BYPASS_EN
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready: got %0b expected 1", alloc_ready); end
        checks++; if (alloc_preg !== 6'd7) begin errors++; $display("FAIL bypass_preg: got %0d expected 7", alloc_preg); end
`else
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL nobypass_ready: got %0b expected 0", alloc_ready); end
`endif
        step();
        idle();
`ifdef FREELIST_BYPASS_EN
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL bypass_empty_after: got %0b expected 1", empty); end
        checks++; if (free_count !== 7'd0) begin errors++; $display("FAIL bypass_count_after: got %0d expected 0", free_count); end
`else
        checks++; if (free_count !== 7'd1) begin errors++; $display("FAIL nobypass_count_after: got %0d expected 1", free_count); end
        checks++; if (alloc_preg !== 6'd7) begin errors++; $display("FAIL nobypass_preg_after: got %0d expected 7", alloc_preg); end
`endif
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            alloc_req          = 1'b1;
            commit_alloc_valid = (i >= 1 && i <= 3);
            step();
        end
        idle();
        checks++; if (free_count !== 7'd55) begin errors++; $display("FAIL flush_setup_count: got %0d expected 55", free_count); end
        checks++; if (alloc_preg !== 6'd9) begin errors++; $display("FAIL flush_setup_preg: got %0d expected 9", alloc_preg); end
        flush = 1'b1;
        step();
        idle();
        checks++; if (alloc_preg !== 6'd4) begin errors++; $display("FAIL flush_preg: got %0d expected 4", alloc_preg); end
        checks++; if (free_count !== 7'd60) begin errors++; $display("FAIL flush_count: got %0d expected 60", free_count); end
    endtask

    task automatic test_flush_commit_alloc();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alloc_req          = 1'b1;
            commit_alloc_valid = (i == 1 || i == 2);
            step();
        end
        idle();
        checks++; if (alloc_preg !== 6'd6) begin errors++; $display("FAIL fca_setup_preg: got %0d expected 6", alloc_preg); end
        checks++; if (free_count !== 7'd58) begin errors++; $display("FAIL fca_setup_count: got %0d expected 58", free_count); end
        flush = 1'b1; commit_alloc_valid = 1'b1; alloc_req = 1'b1;
        step();
        idle();
        checks++; if (alloc_preg !== 6'd4) begin errors++; $display("FAIL fca_preg: got %0d expected 4", alloc_preg); end
        checks++; if (free_count !== 7'd60) begin errors++; $display("FAIL fca_count: got %0d expected 60", free_count); end
        alloc_req = 1'b1;
        step();
        idle();
        checks++; if (alloc_preg !== 6'd5) begin errors++; $display("FAIL fca_next_preg: got %0d expected 5", alloc_preg); end
    endtask

    task automatic test_reset_mid();
        alloc_req = 1'b1; release_valid = 1'b1; release_preg = 6'd5;
        #2;
        reset = 1'b1;   // asserted while clk is high, away from any edge
        #1;
        checks++; if (free_count !== 7'd63) begin errors++; $display("FAIL async_reset_count: got %0d expected 63", free_count); end
        checks++; if (alloc_preg !== 6'd1) begin errors++; $display("FAIL async_reset_preg: got %0d expected 1", alloc_preg); end
        idle();
        @(negedge clk);
        reset = 1'b0;
        step();
        checks++; if (free_count !== 7'd63) begin errors++; $display("FAIL post_reset_count: got %0d expected 63", free_count); end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_release_p0();
        test_drain();
        test_alloc_release();
        test_empty_release();
        test_flush();
        test_flush_commit_alloc();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
